// File: rtl/cpu_seq.sv
// Control sequencer for a small accumulator CPU: fetch/decode/execute FSM with bounded memory waits.
// Optional stack instructions (push/pop) are built only when CPU_SEQ_STACK_EN is defined.
module cpu_seq #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic [17:0] op,
    input  logic        zf,
    input  logic        bf,
    input  logic        mem_rdy,
    output logic        pc_oe,
    output logic        mar_ld,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        iir,
    output logic        eir,
    output logic        pc_inc,
    output logic        pc_ld,
    output logic        acc_ld,
    output logic        flags_ld,
    output logic        sp_inc,
    output logic        sp_dec,
    output logic        sp_oe,
    output logic [3:0]  alu_op,
    output logic [2:0]  state,
    output logic        illegal_op,
    output logic        mem_err
);

    localparam int CNT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    localparam logic [3:0] ALU_PASSB = 4'd0;
    localparam logic [3:0] ALU_SHL   = 4'd1;
    localparam logic [3:0] ALU_ADD   = 4'd2;
    localparam logic [3:0] ALU_SUB   = 4'd3;
    localparam logic [3:0] ALU_XOR   = 4'd4;
    localparam logic [3:0] ALU_OR    = 4'd5;
    localparam logic [3:0] ALU_AND   = 4'd6;
    localparam logic [3:0] ALU_SHR   = 4'd7;
    localparam logic [3:0] ALU_NOT   = 4'd8;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_LOADIR = 3'd2,
        S_DECODE = 3'd3,
        S_EXEC   = 3'd4,
        S_MEM    = 3'd5,
        S_WB     = 3'd6
    } state_t;

    // Kind of data access in flight, captured in EXEC so MEM does not depend on op
    typedef enum logic [1:0] {
        K_LD   = 2'd0,
        K_ST   = 2'd1,
        K_PUSH = 2'd2,
        K_POP  = 2'd3
    } kind_t;

    state_t          state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    kind_t           kind_reg, kind_next;

`ifdef CPU_SEQ_STACK_EN
    logic addr_ph_reg, addr_ph_next;
    logic sp_inc_c, sp_dec_c, sp_oe_c;
`endif

    // One-hot op vector -> bit index
    logic [4:0] idx_term [18];
    logic [4:0] op_idx;
    logic       op_onehot;
    logic       op_legal;

    generate
        for (genvar gi = 0; gi < 18; gi++) begin : g_idx
            assign idx_term[gi] = op[gi] ? 5'(gi) : 5'd0;
        end
    endgenerate

    always_comb begin
        op_idx = 5'd0;
        for (int i = 0; i < 18; i++) begin
            op_idx = op_idx | idx_term[i];
        end
    end

    assign op_onehot = (op != 18'd0) && ((op & (op - 18'd1)) == 18'd0);

`ifdef CPU_SEQ_STACK_EN
    assign op_legal = op_onehot;
`else
    assign op_legal = op_onehot && !op[16] && !op[17];
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
            kind_reg  <= K_LD;
`ifdef CPU_SEQ_STACK_EN
            addr_ph_reg <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            kind_reg  <= kind_next;
`ifdef CPU_SEQ_STACK_EN
            addr_ph_reg <= addr_ph_next;
`endif
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        kind_next  = kind_reg;
        pc_oe      = 1'b0;
        mar_ld     = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        iir        = 1'b0;
        eir        = 1'b0;
        pc_inc     = 1'b0;
        pc_ld      = 1'b0;
        acc_ld     = 1'b0;
        flags_ld   = 1'b0;
        alu_op     = ALU_PASSB;
        illegal_op = 1'b0;
        mem_err    = 1'b0;
`ifdef CPU_SEQ_STACK_EN
        addr_ph_next = addr_ph_reg;
        sp_inc_c     = 1'b0;
        sp_dec_c     = 1'b0;
        sp_oe_c      = 1'b0;
`endif

        case (state_reg)
            S_IDLE: begin
                if (run) state_next = S_FETCH;
            end

            S_FETCH: begin
                pc_oe      = 1'b1;
                mar_ld     = 1'b1;
                cnt_next   = '0;
                state_next = S_LOADIR;
            end

            // mem_rdy on the limit cycle still wins over the timeout
            S_LOADIR: begin
                if (mem_rdy) begin
                    mem_rd     = 1'b1;
                    iir        = 1'b1;
                    pc_inc     = 1'b1;
                    state_next = S_DECODE;
                end else if (cnt_reg == CNT_LIMIT) begin
                    mem_err    = 1'b1;
                    cnt_next   = '0;
                    state_next = S_IDLE;
                end else begin
                    mem_rd   = 1'b1;
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end

            S_DECODE: begin
                state_next = S_EXEC;
            end

            S_EXEC: begin
                state_next = S_FETCH;
                cnt_next   = '0;
                if (!op_legal) begin
                    illegal_op = 1'b1;
                end else begin
                    case (op_idx)
                        5'd1: begin
                            eir        = 1'b1;
                            mar_ld     = 1'b1;
                            kind_next  = K_LD;
                            state_next = S_MEM;
                        end
                        5'd2: begin
                            eir    = 1'b1;
                            acc_ld = 1'b1;
                        end
                        5'd3: begin
                            alu_op   = ALU_SUB;
                            flags_ld = 1'b1;
                        end
                        5'd4: begin
                            eir        = 1'b1;
                            mar_ld     = 1'b1;
                            kind_next  = K_ST;
                            state_next = S_MEM;
                        end
                        5'd5:  begin alu_op = ALU_SHL; acc_ld = 1'b1; flags_ld = 1'b1; end
                        5'd6:  begin alu_op = ALU_ADD; acc_ld = 1'b1; flags_ld = 1'b1; end
                        5'd7:  begin alu_op = ALU_SUB; acc_ld = 1'b1; flags_ld = 1'b1; end
                        5'd8:  begin eir = 1'b1; pc_ld = zf; end
                        5'd9:  begin eir = 1'b1; pc_ld = bf; end
                        5'd10: begin eir = 1'b1; pc_ld = 1'b1; end
                        5'd11: begin alu_op = ALU_XOR; acc_ld = 1'b1; flags_ld = 1'b1; end
                        5'd12: begin alu_op = ALU_OR;  acc_ld = 1'b1; flags_ld = 1'b1; end
                        5'd13: begin alu_op = ALU_AND; acc_ld = 1'b1; flags_ld = 1'b1; end
                        5'd14: begin alu_op = ALU_SHR; acc_ld = 1'b1; flags_ld = 1'b1; end
                        5'd15: begin alu_op = ALU_NOT; acc_ld = 1'b1; flags_ld = 1'b1; end
`ifdef CPU_SEQ_STACK_EN
                        5'd16: begin
                            sp_dec_c     = 1'b1;
                            kind_next    = K_PUSH;
                            addr_ph_next = 1'b1;
                            state_next   = S_MEM;
                        end
                        5'd17: begin
                            sp_oe_c    = 1'b1;
                            mar_ld     = 1'b1;
                            kind_next  = K_POP;
                            state_next = S_MEM;
                        end
`endif
                        default: ;
                    endcase
                end
            end

            S_MEM: begin
`ifdef CPU_SEQ_STACK_EN
                // push spends its first MEM cycle latching the decremented SP into MAR
                if (addr_ph_reg) begin
                    sp_oe_c      = 1'b1;
                    mar_ld       = 1'b1;
                    addr_ph_next = 1'b0;
                    cnt_next     = '0;
                end else
`endif
                if (mem_rdy) begin
                    mem_rd = (kind_reg == K_LD) || (kind_reg == K_POP);
                    mem_wr = (kind_reg == K_ST) || (kind_reg == K_PUSH);
`ifdef CPU_SEQ_STACK_EN
                    sp_inc_c = (kind_reg == K_POP);
`endif
                    cnt_next   = '0;
                    state_next = ((kind_reg == K_LD) || (kind_reg == K_POP)) ? S_WB : S_FETCH;
                end else if (cnt_reg == CNT_LIMIT) begin
                    mem_err    = 1'b1;
                    cnt_next   = '0;
                    state_next = S_IDLE;
                end else begin
                    mem_rd   = (kind_reg == K_LD) || (kind_reg == K_POP);
                    mem_wr   = (kind_reg == K_ST) || (kind_reg == K_PUSH);
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end

            S_WB: begin
                acc_ld     = 1'b1;
                state_next = S_FETCH;
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

`ifdef CPU_SEQ_STACK_EN
    assign sp_inc = sp_inc_c;
    assign sp_dec = sp_dec_c;
    assign sp_oe  = sp_oe_c;
`else
    assign sp_inc = 1'b0;
    assign sp_dec = 1'b0;
    assign sp_oe  = 1'b0;
`endif

    assign state = state_reg;

endmodule

// File: tb/tb_cpu_seq.sv
// Directed scoreboard bench for cpu_seq: each cycle's expected outputs are queued, then
// popped and compared at the falling edge.
module tb_cpu_seq;

    logic        clk = 1'b0;
    logic        rst_n, run, zf, bf, mem_rdy;
    logic [17:0] op;
    logic        pc_oe, mar_ld, mem_rd, mem_wr, iir, eir, pc_inc, pc_ld;
    logic        acc_ld, flags_ld, sp_inc, sp_dec, sp_oe, illegal_op, mem_err;
    logic [3:0]  alu_op;
    logic [2:0]  state;

    cpu_seq #(.MEM_TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .op(op), .zf(zf), .bf(bf), .mem_rdy(mem_rdy),
        .pc_oe(pc_oe), .mar_ld(mar_ld), .mem_rd(mem_rd), .mem_wr(mem_wr), .iir(iir),
        .eir(eir), .pc_inc(pc_inc), .pc_ld(pc_ld), .acc_ld(acc_ld), .flags_ld(flags_ld),
        .sp_inc(sp_inc), .sp_dec(sp_dec), .sp_oe(sp_oe), .alu_op(alu_op), .state(state),
        .illegal_op(illegal_op), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    localparam logic [12:0] PC_OE    = 13'h0001;
    localparam logic [12:0] MAR_LD   = 13'h0002;
    localparam logic [12:0] MEM_RD   = 13'h0004;
    localparam logic [12:0] MEM_WR   = 13'h0008;
    localparam logic [12:0] IIR      = 13'h0010;
    localparam logic [12:0] EIR      = 13'h0020;
    localparam logic [12:0] PC_INC   = 13'h0040;
    localparam logic [12:0] PC_LD    = 13'h0080;
    localparam logic [12:0] ACC_LD   = 13'h0100;
    localparam logic [12:0] FLAGS_LD = 13'h0200;
    localparam logic [12:0] SP_INC   = 13'h0400;
    localparam logic [12:0] SP_DEC   = 13'h0800;
    localparam logic [12:0] SP_OE    = 13'h1000;

    // {state, alu_op, illegal_op, mem_err, strobes}
    logic [21:0] obs;
    assign obs = {state, alu_op, illegal_op, mem_err, sp_oe, sp_dec, sp_inc, flags_ld, acc_ld,
                  pc_ld, pc_inc, eir, iir, mem_wr, mem_rd, mar_ld, pc_oe};

    typedef struct {
        string       tag;
        logic [21:0] exp;
    } sb_t;

    sb_t sb_q[$];
    int  checks = 0;
    int  errors = 0;

    function automatic logic [17:0] opb(input int n);
        logic [17:0] one;
        one = 18'd1;
        return one << n;
    endfunction

    task automatic push_exp(input string tag, input logic [2:0] st, input logic [3:0] alu,
                            input logic ill, input logic merr, input logic [12:0] stb);
        sb_t e;
        e.tag = tag;
        e.exp = {st, alu, ill, merr, stb};
        sb_q.push_back(e);
    endtask

    task automatic check_cycle();
        sb_t e;
        @(negedge clk);
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty: observed %h expected a queued entry", obs);
        end else begin
            e = sb_q.pop_front();
            assert (obs === e.exp) else begin
                errors++;
                $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step(input string tag, input logic [2:0] st, input logic [3:0] alu,
                        input logic ill, input logic merr, input logic [12:0] stb);
        push_exp(tag, st, alu, ill, merr, stb);
        check_cycle();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start();
        run = 1'b1;
        step("idle_run", 3'd0, 4'd0, 1'b0, 1'b0, 13'h0);
        run = 1'b0;
    endtask

    // FETCH, LOADIR with 'delay' stall cycles, DECODE; leaves the DUT entering EXEC
    task automatic fetch(input logic [17:0] o, input int delay);
        op = o;
        mem_rdy = 1'b0;
        step("fetch", 3'd1, 4'd0, 1'b0, 1'b0, PC_OE | MAR_LD);
        for (int i = 0; i < delay; i++) step("ldir_wait", 3'd2, 4'd0, 1'b0, 1'b0, MEM_RD);
        mem_rdy = 1'b1;
        step("ldir_done", 3'd2, 4'd0, 1'b0, 1'b0, MEM_RD | IIR | PC_INC);
        mem_rdy = 1'b0;
        step("decode", 3'd3, 4'd0, 1'b0, 1'b0, 13'h0);
    endtask

    initial begin
        int          alu_bit [7];
        logic [3:0]  alu_code [7];
        alu_bit  = '{5, 7, 11, 12, 13, 14, 15};
        alu_code = '{4'd1, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};

        rst_n = 1'b0; run = 1'b0; op = 18'd1; zf = 1'b0; bf = 1'b0; mem_rdy = 1'b0;
        tick();
        tick();
        step("reset_idle", 3'd0, 4'd0, 1'b0, 1'b0, 13'h0);
        rst_n = 1'b1;
        step("idle_hold", 3'd0, 4'd0, 1'b0, 1'b0, 13'h0);

        start();
        fetch(opb(0), 0);
        step("exec_nop", 3'd4, 4'd0, 1'b0, 1'b0, 13'h0);

        fetch(opb(6), 3);
        step("exec_add", 3'd4, 4'd2, 1'b0, 1'b0, ACC_LD | FLAGS_LD);

        for (int i = 0; i < 7; i++) begin
            fetch(opb(alu_bit[i]), 0);
            step("exec_alu", 3'd4, alu_code[i], 1'b0, 1'b0, ACC_LD | FLAGS_LD);
        end

        fetch(opb(2), 0);
        step("exec_ln", 3'd4, 4'd0, 1'b0, 1'b0, EIR | ACC_LD);
        fetch(opb(3), 0);
        step("exec_cp", 3'd4, 4'd3, 1'b0, 1'b0, FLAGS_LD);

        fetch(opb(8), 0); zf = 1'b0;
        step("jz_not_taken", 3'd4, 4'd0, 1'b0, 1'b0, EIR);
        fetch(opb(8), 0); zf = 1'b1;
        step("jz_taken", 3'd4, 4'd0, 1'b0, 1'b0, EIR | PC_LD);
        fetch(opb(9), 0); bf = 1'b1; zf = 1'b0;
        step("jb_taken", 3'd4, 4'd0, 1'b0, 1'b0, EIR | PC_LD);
        fetch(opb(9), 0); bf = 1'b0; zf = 1'b1;
        step("jb_not_taken", 3'd4, 4'd0, 1'b0, 1'b0, EIR);
        zf = 1'b0;
        fetch(opb(10), 0);
        step("exec_jmp", 3'd4, 4'd0, 1'b0, 1'b0, EIR | PC_LD);

        fetch(opb(1), 0);
        step("exec_ld", 3'd4, 4'd0, 1'b0, 1'b0, EIR | MAR_LD);
        for (int i = 0; i < 2; i++) step("ld_wait", 3'd5, 4'd0, 1'b0, 1'b0, MEM_RD);
        mem_rdy = 1'b1;
        step("ld_done", 3'd5, 4'd0, 1'b0, 1'b0, MEM_RD);
        mem_rdy = 1'b0;
        step("ld_wb", 3'd6, 4'd0, 1'b0, 1'b0, ACC_LD);

        fetch(opb(4), 0);
        step("exec_st", 3'd4, 4'd0, 1'b0, 1'b0, EIR | MAR_LD);
        mem_rdy = 1'b1;
        step("st_done", 3'd5, 4'd0, 1'b0, 1'b0, MEM_WR);
        mem_rdy = 1'b0;

        fetch(18'h00003, 0);
        step("illegal_multi", 3'd4, 4'd0, 1'b1, 1'b0, 13'h0);
        fetch(18'h00000, 0);
        step("illegal_zero", 3'd4, 4'd0, 1'b1, 1'b0, 13'h0);

`ifdef CPU_SEQ_STACK_EN
        fetch(opb(16), 0);
        step("exec_push", 3'd4, 4'd0, 1'b0, 1'b0, SP_DEC);
        mem_rdy = 1'b1;
        step("push_addr", 3'd5, 4'd0, 1'b0, 1'b0, SP_OE | MAR_LD);
        step("push_wr", 3'd5, 4'd0, 1'b0, 1'b0, MEM_WR);
        mem_rdy = 1'b0;
        fetch(opb(17), 0);
        step("exec_pop", 3'd4, 4'd0, 1'b0, 1'b0, SP_OE | MAR_LD);
        mem_rdy = 1'b1;
        step("pop_rd", 3'd5, 4'd0, 1'b0, 1'b0, MEM_RD | SP_INC);
        mem_rdy = 1'b0;
        step("pop_wb", 3'd6, 4'd0, 1'b0, 1'b0, ACC_LD);
`else
        fetch(opb(16), 0);
        step("push_illegal", 3'd4, 4'd0, 1'b1, 1'b0, 13'h0);
        fetch(opb(17), 0);
        step("pop_illegal", 3'd4, 4'd0, 1'b1, 1'b0, 13'h0);
`endif

        // st never acknowledged: 15 wait cycles then the timeout pulse
        fetch(opb(4), 0);
        step("exec_st_to", 3'd4, 4'd0, 1'b0, 1'b0, EIR | MAR_LD);
        for (int i = 0; i < 15; i++) step("st_wait", 3'd5, 4'd0, 1'b0, 1'b0, MEM_WR);
        step("st_timeout", 3'd5, 4'd0, 1'b0, 1'b1, 13'h0);
        step("idle_after_st_to", 3'd0, 4'd0, 1'b0, 1'b0, 13'h0);

        // mem_rdy on the limit cycle completes the access
        start();
        fetch(opb(1), 0);
        step("exec_ld_edge", 3'd4, 4'd0, 1'b0, 1'b0, EIR | MAR_LD);
        for (int i = 0; i < 15; i++) step("ld_wait_edge", 3'd5, 4'd0, 1'b0, 1'b0, MEM_RD);
        mem_rdy = 1'b1;
        step("ld_last_chance", 3'd5, 4'd0, 1'b0, 1'b0, MEM_RD);
        mem_rdy = 1'b0;
        step("ld_edge_wb", 3'd6, 4'd0, 1'b0, 1'b0, ACC_LD);

        op = opb(0);
        step("fetch_ldir_to", 3'd1, 4'd0, 1'b0, 1'b0, PC_OE | MAR_LD);
        for (int i = 0; i < 15; i++) step("ldir_wait_to", 3'd2, 4'd0, 1'b0, 1'b0, MEM_RD);
        step("ldir_timeout", 3'd2, 4'd0, 1'b0, 1'b1, 13'h0);
        step("idle_after_ldir_to", 3'd0, 4'd0, 1'b0, 1'b0, 13'h0);

        // reset in the middle of a ld data wait
        start();
        fetch(opb(1), 0);
        step("exec_ld_rst", 3'd4, 4'd0, 1'b0, 1'b0, EIR | MAR_LD);
        step("ld_wait_rst", 3'd5, 4'd0, 1'b0, 1'b0, MEM_RD);
        rst_n = 1'b0;
        tick();
        mem_rdy = 1'b1;
        step("rst_abort", 3'd0, 4'd0, 1'b0, 1'b0, 13'h0);
        rst_n = 1'b1;
        mem_rdy = 1'b0;
        step("idle_after_rst", 3'd0, 4'd0, 1'b0, 1'b0, 13'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_seq.md
CPU_SEQ -- requirements
Module: cpu_seq

Interface
REQ-001 Parameter MEM_TIMEOUT, default 15, is the maximum number of cycles spent waiting for mem_rdy before the access is abandoned.
REQ-002 clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset; synchronous, active-low.
REQ-004 run  input  1  start/continue execution; sampled in IDLE only.
REQ-005 op  input  18  one-hot decoded instruction from the instruction register (bit0 nop, 1 ld, 2 ln, 3 cp, 4 st, 5 shl, 6 add, 7 sub, 8 jz, 9 jb, 10 jmp, 11 xor, 12 or, 13 and, 14 shr, 15 not, 16 push, 17 pop).
REQ-006 zf, bf  input  1 each  ALU zero and borrow flags, valid in EXEC.
REQ-007 mem_rdy  input  1  memory completes the current rd/wr access this cycle.
REQ-008 Strobes, output, 1 bit each: pc_oe, mar_ld, mem_rd, mem_wr, iir, eir, pc_inc, pc_ld, acc_ld, flags_ld, sp_inc, sp_dec, sp_oe.
REQ-009 alu_op  output  4  ALU function: 0 passB, 1 shl, 2 add, 3 sub, 4 xor, 5 or, 6 and, 7 shr, 8 not.
REQ-010 state  output  3  current state code; illegal_op, mem_err  output  1 each  single-cycle fault pulses.

Function
REQ-011 States and codes: IDLE=0, FETCH=1, LOADIR=2, DECODE=3, EXEC=4, MEM=5, WB=6.
REQ-012 IDLE: all strobes 0; run=1 -> FETCH next cycle; run=0 -> stay.
REQ-013 FETCH: pc_oe=1, mar_ld=1 for exactly one cycle -> LOADIR.
REQ-014 LOADIR: mem_rd=1 held until mem_rdy; in the mem_rdy cycle iir=1 and pc_inc=1 -> DECODE.
REQ-015 DECODE: exactly one cycle with no strobes, so the op vector settles -> EXEC.
REQ-016 EXEC, nop: no strobes -> FETCH.
REQ-017 EXEC, ln: eir=1, alu_op=0, acc_ld=1 -> FETCH.
REQ-018 EXEC, shl/add/sub/xor/or/and/shr/not: alu_op per REQ-009, acc_ld=1, flags_ld=1 -> FETCH.
REQ-019 EXEC, cp: alu_op=3, flags_ld=1, acc_ld=0 -> FETCH.
REQ-020 EXEC, jmp: eir=1, pc_ld=1 -> FETCH; jz/jb: eir=1, and pc_ld=zf (jz) or bf (jb) -> FETCH.
REQ-021 EXEC, ld/st: eir=1, mar_ld=1 -> MEM.
REQ-022 MEM: ld drives mem_rd=1 and st drives mem_wr=1, held until mem_rdy; on mem_rdy ld -> WB and st -> FETCH.
REQ-023 WB: acc_ld=1 with alu_op=0 -> FETCH.
REQ-024 A zero or multi-hot op in EXEC pulses illegal_op, is executed as nop -> FETCH.
REQ-025 Every strobe is a Moore/Mealy function of the state register only, plus op, zf, bf and mem_rdy; there is no combinational path from run.
REQ-026 Wait counter: resets to 0 on entry to LOADIR or MEM and increments each waiting cycle.
REQ-027 Timeout: when the counter reaches MEM_TIMEOUT without mem_rdy, mem_err pulses for one cycle, strobes drop and the block returns to IDLE.
REQ-028 mem_rdy arriving in the same cycle as the timeout counts as success.
REQ-029 Wait counter width is clog2(MEM_TIMEOUT+1) bits and it does not wrap.
REQ-030 run is ignored outside IDLE; execution is free-running once started.

Reset
REQ-031 rst_n=0 at a clock edge forces IDLE, a wait counter of 0, and all strobes, alu_op, illegal_op and mem_err to 0, from the following cycle.
REQ-032 Reset mid-access aborts it with no completing strobe (no acc_ld, no iir).

Configuration
REQ-033 With macro CPU_SEQ_STACK_EN defined, push executes as EXEC sp_dec=1 -> MEM (sp_oe=1, mar_ld=1 in the first MEM cycle, then mem_wr held until mem_rdy) -> FETCH.
REQ-034 With CPU_SEQ_STACK_EN defined, pop executes as EXEC sp_oe=1, mar_ld=1 -> MEM (mem_rd until mem_rdy, then sp_inc=1) -> WB.
REQ-035 Without CPU_SEQ_STACK_EN, push/pop are treated as illegal per REQ-024, and sp_inc, sp_dec and sp_oe are tied to 0.

Verification
REQ-036 Reset then run=1, op=nop, mem_rdy=1 always -> state 0,1,2,3,4,1; iir and pc_inc high only in cycle 3.
REQ-037 op=add, mem_rdy delayed 3 cycles in LOADIR -> mem_rd high 4 cycles, then acc_ld=1, flags_ld=1, alu_op=2 in EXEC.
REQ-038 op=jz with zf=0 then with zf=1 -> pc_ld 0 then 1; op=jb with bf=1 -> pc_ld=1.
REQ-039 op=st, mem_rdy never asserted, MEM_TIMEOUT=15 -> mem_err pulses after 15 wait cycles and state returns to 0.
REQ-040 op=18'h00003 -> illegal_op pulses once; rst_n=0 during ld MEM -> IDLE next cycle with no acc_ld.
REQ-041 With CPU_SEQ_STACK_EN, push then pop -> sp_dec once, mem_wr, then sp_inc once and acc_ld in WB; without the macro, push -> illegal_op.
